// File: rtl/stream_frame_sink.sv
// Frame-tagging sink for the stream buffer read side: skid FIFO, stall, frame checks.
// Optional STREAM_FRAME_SINK_STATS_EN adds dropped-word and FIFO high-water counters.
module stream_frame_sink #(
    parameter int CHANNELS     = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int SKID_DEPTH   = 4,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0] in_channels_i,
    input  logic                                in_valid_i,
    input  logic                                in_sof_i,
    output logic                                in_stall_o,
    output logic [CHANNELS-1:0][DATA_WIDTH-1:0] out_channels_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                out_sof_o,
    output logic                                out_eol_o,
    output logic                                out_eof_o,
    output logic [15:0]                         frame_count_o,
`ifdef STREAM_FRAME_SINK_STATS_EN
    output logic [31:0]                         dropped_words_o,
    output logic [$clog2(SKID_DEPTH):0]         max_occupancy_o,
`endif
    output logic                                err_early_sof_o,
    output logic                                err_missing_sof_o,
    output logic                                err_overflow_o
);

    localparam int AW = $clog2(SKID_DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] XLAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] YLAST = YW'(FRAME_HEIGHT - 1);

    typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] word_t;
    typedef struct packed {
        logic  sof;
        word_t data;
    } entry_t;

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, NEXT_SOF} state_t;

    entry_t        mem [SKID_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    state_t        state;
    logic [XW-1:0] cx, x, lx, nx;
    logic [YW-1:0] cy, y, ly, ny;

    entry_t head;
    logic   full, empty, pop, push_ok, overflow, handshake;
    logic   load, discard, restart, set_early, set_miss, frame_end;

    assign head      = mem[rd_ptr];
    assign full      = (count == CW'(SKID_DEPTH));
    assign empty     = (count == '0);
    assign pop       = !empty && (!out_valid_o || out_ready_i);
    assign push_ok   = in_valid_i && (!full || pop);
    assign overflow  = in_valid_i && !push_ok;
    assign handshake = out_valid_o && out_ready_i;
    assign count_next = count + CW'(push_ok) - CW'(pop);

    // cx/cy is the position the next loaded word will take
    always_comb begin
        load      = 1'b0;
        discard   = 1'b0;
        restart   = 1'b0;
        set_early = 1'b0;
        set_miss  = 1'b0;
        if (pop) begin
            unique case (state)
                WAIT_SOF: begin
                    load    = head.sof;
                    discard = !head.sof;
                    restart = head.sof;
                end
                NEXT_SOF: begin
                    load     = head.sof;
                    discard  = !head.sof;
                    restart  = head.sof;
                    set_miss = !head.sof;
                end
                ACTIVE: begin
                    load      = 1'b1;
                    set_early = head.sof && (cx != '0 || cy != '0);
                    restart   = set_early;
                end
                default: discard = 1'b1;
            endcase
        end
    end

    assign lx        = restart ? '0 : cx;
    assign ly        = restart ? '0 : cy;
    assign frame_end = (lx == XLAST) && (ly == YLAST);
    assign nx        = (lx == XLAST) ? '0 : lx + 1'b1;
    assign ny        = (lx != XLAST) ? ly : ((ly == YLAST) ? '0 : ly + 1'b1);

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= {in_sof_i, in_channels_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            in_stall_o        <= 1'b1;
            state             <= WAIT_SOF;
            cx                <= '0;
            cy                <= '0;
            x                 <= '0;
            y                 <= '0;
            out_channels_o    <= '0;
            out_valid_o       <= 1'b0;
            frame_count_o     <= '0;
            err_early_sof_o   <= 1'b0;
            err_missing_sof_o <= 1'b0;
            err_overflow_o    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            in_stall_o <= (count_next >= CW'(SKID_DEPTH - 2));
            if (overflow) err_overflow_o <= 1'b1;
            if (set_early) err_early_sof_o <= 1'b1;
            if (set_miss) err_missing_sof_o <= 1'b1;
            if (handshake && x == XLAST && y == YLAST)
                frame_count_o <= frame_count_o + 1'b1;
            if (load) begin
                out_channels_o <= head.data;
                out_valid_o    <= 1'b1;
                x              <= lx;
                y              <= ly;
                cx             <= frame_end ? '0 : nx;
                cy             <= frame_end ? '0 : ny;
                state          <= frame_end ? NEXT_SOF : ACTIVE;
            end else begin
                if (out_ready_i) out_valid_o <= 1'b0;
                if (set_miss) state <= WAIT_SOF;
            end
        end
    end

    assign out_sof_o = out_valid_o && x == '0 && y == '0;
    assign out_eol_o = out_valid_o && x == XLAST;
    assign out_eof_o = out_valid_o && x == XLAST && y == YLAST;

`ifdef STREAM_FRAME_SINK_STATS_EN
    logic [32:0] drop_sum;
    assign drop_sum = {1'b0, dropped_words_o} + 33'(discard) + 33'(overflow);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dropped_words_o <= '0;
            max_occupancy_o <= '0;
        end else begin
            dropped_words_o <= drop_sum[32] ? '1 : drop_sum[31:0];
            if (count_next > max_occupancy_o) max_occupancy_o <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_stream_frame_sink.sv
// Randomised scoreboard bench for stream_frame_sink (4x2 frames, depth-4 skid).
module tb_stream_frame_sink;

    localparam int CH = 1;
    localparam int DW = 16;
    localparam int SD = 4;
    localparam int FW = 4;
    localparam int FH = 2;
    localparam int N  = FW * FH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0][DW-1:0] in_ch = '0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic in_stall;
    logic [CH-1:0][DW-1:0] out_ch;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_sof, out_eol, out_eof;
    logic [15:0] frame_count;
    logic err_early, err_miss, err_ovf;
`ifdef STREAM_FRAME_SINK_STATS_EN
    logic [31:0] dropped;
    logic [$clog2(SD):0] max_occ;
`endif

    always #5 clk = ~clk;

    stream_frame_sink #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .SKID_DEPTH(SD),
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .in_channels_i(in_ch),
        .in_valid_i(in_valid),
        .in_sof_i(in_sof),
        .in_stall_o(in_stall),
        .out_channels_o(out_ch),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sof_o(out_sof),
        .out_eol_o(out_eol),
        .out_eof_o(out_eof),
        .frame_count_o(frame_count),
`ifdef STREAM_FRAME_SINK_STATS_EN
        .dropped_words_o(dropped),
        .max_occupancy_o(max_occ),
`endif
        .err_early_sof_o(err_early),
        .err_missing_sof_o(err_miss),
        .err_overflow_o(err_ovf)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic sof, eol, eof;
        logic [15:0] fc;
    } exp_t;
    typedef struct {
        logic s;
        logic [DW-1:0] d;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int total = 0;
    int bad = 0;

    // reference: a frame is N consecutive accepted words, indexed 0..N-1
    bit m_sync;
    int m_pos;
    logic [15:0] m_frames;
    bit m_early, m_miss;
    int m_drop;

    bit pend;
    stim_t pend_w;
    bit rand_rdy = 1'b0;
    bit rdy_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic emit(input logic [DW-1:0] d);
        exp_t e;
        e.d   = d;
        e.sof = (m_pos == 0);
        e.eol = ((m_pos % FW) == FW - 1);
        e.eof = (m_pos == N - 1);
        e.fc  = m_frames;
        exp_q.push_back(e);
        if (e.eof) m_frames = m_frames + 16'd1;
        m_pos = (m_pos + 1) % N;
    endtask

    task automatic model_word(input logic s, input logic [DW-1:0] d);
        if (!m_sync) begin
            if (s) begin
                m_sync = 1'b1;
                m_pos = 0;
                emit(d);
            end else m_drop++;
        end else if (m_pos == 0) begin
            if (s) emit(d);
            else begin
                m_miss = 1'b1;
                m_sync = 1'b0;
                m_drop++;
            end
        end else begin
            if (s) begin
                m_early = 1'b1;
                m_pos = 0;
            end
            emit(d);
        end
    endtask

    // source with one cycle of read latency that honours in_stall
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_valid = 1'b0;
            pend = 1'b0;
            m_sync = 1'b0;
            m_pos = 0;
            m_frames = '0;
            m_early = 1'b0;
            m_miss = 1'b0;
            m_drop = 0;
            exp_q.delete();
        end else begin
            in_valid = pend;
            if (pend) begin
                in_ch  = pend_w.d;
                in_sof = pend_w.s;
                model_word(pend_w.s, pend_w.d);
            end else begin
                in_ch  = DW'($urandom);
                in_sof = 1'($urandom);
            end
            pend = 1'b0;
            if (!in_stall && stim_q.size() > 0) begin
                pend_w = stim_q.pop_front();
                pend = 1'b1;
            end
        end
        out_ready = rdy_low ? 1'b0 : (rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
    end

    logic hold_v;
    logic [DW+2:0] hold_s;
    always @(negedge clk) begin
        if (!rst_n || !out_valid) hold_v = 1'b0;
        else begin
            if (hold_v) chk("hold_stable", {out_ch, out_sof, out_eol, out_eof}, hold_s);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h want none at %0t", out_ch, $time);
            end else begin
                chk("data", out_ch, exp_q[0].d);
                chk("tags", {out_sof, out_eol, out_eof},
                    {exp_q[0].sof, exp_q[0].eol, exp_q[0].eof});
                chk("frame_count_at_word", frame_count, exp_q[0].fc);
                if (out_ready) void'(exp_q.pop_front());
            end
            hold_v = !out_ready;
            hold_s = {out_ch, out_sof, out_eol, out_eof};
        end
    end

    task automatic push_frame(input int junk, input int early_at);
        stim_t w;
        for (int i = 0; i < junk; i++) begin
            w.s = 1'b0;
            w.d = DW'($urandom);
            stim_q.push_back(w);
        end
        for (int i = 0; i < N; i++) begin
            w.s = (i == 0) || (i == early_at);
            w.d = DW'($urandom);
            stim_q.push_back(w);
        end
    endtask

    task automatic push_plain(input int n);
        stim_t w;
        for (int i = 0; i < n; i++) begin
            w.s = 1'b0;
            w.d = DW'($urandom);
            stim_q.push_back(w);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((stim_q.size() > 0 || pend || in_valid || exp_q.size() > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_%s: got %0d words outstanding want 0", name, exp_q.size());
        end
        repeat (12) @(posedge clk);
        #2;
    endtask

    task automatic check_state(input string name);
        chk({name, "_frames"}, frame_count, m_frames);
        chk({name, "_early"}, err_early, m_early);
        chk({name, "_miss"}, err_miss, m_miss);
        chk({name, "_ovf"}, err_ovf, 1'b0);
`ifdef STREAM_FRAME_SINK_STATS_EN
        chk({name, "_dropped"}, dropped, m_drop);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_stall", in_stall, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_tags", {out_sof, out_eol, out_eof}, 3'b000);
        chk("rst_frames", frame_count, 16'd0);
        chk("rst_errs", {err_early, err_miss, err_ovf}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("stall_after_rst", in_stall, 1'b0);

        push_frame(3, -1);
        drain("junk");
        check_state("junk");
        chk("junk_frames_abs", frame_count, 16'd1);

        push_frame(0, -1);
        drain("basic");
        check_state("basic");
        chk("basic_errs_abs", {err_early, err_miss, err_ovf}, 3'b000);

        rdy_low = 1'b1;
        push_frame(0, -1);
        repeat (20) @(posedge clk);
        #2;
        chk("bp_stall", in_stall, 1'b1);
        chk("bp_ovf", err_ovf, 1'b0);
        rdy_low = 1'b0;
        drain("bp");
        check_state("bp");

        push_frame(0, 5);
        push_plain(N - 3);
        drain("early");
        check_state("early");
        chk("early_flag_abs", err_early, 1'b1);

        push_frame(0, -1);
        push_plain(3);
        push_frame(0, -1);
        drain("miss");
        check_state("miss");
        chk("miss_flag_abs", err_miss, 1'b1);

        rand_rdy = 1'b1;
        for (int f = 0; f < 15; f++)
            push_frame($urandom_range(3) == 0 ? $urandom_range(1, 2) : 0,
                       $urandom_range(4) == 0 ? $urandom_range(1, N - 1) : -1);
        drain("random");
        check_state("random");
        rand_rdy = 1'b0;

        rdy_low = 1'b1;
        push_frame(0, -1);
        push_frame(0, -1);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_stall", in_stall, 1'b1);
        chk("mid_rst_frames", frame_count, 16'd0);
        chk("mid_rst_errs", {err_early, err_miss, err_ovf}, 3'b000);
        stim_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_low = 1'b0;
        push_frame(0, -1);
        drain("post_rst");
        check_state("post_rst");
        chk("post_rst_frames_abs", frame_count, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
